// File: rtl/mrd_sink_buf_wr.sv
// Input stage of the mixed-radix DFT core: turns the Avalon-ST-style sample stream into
// round-robin writes across the 5-bank sample buffer and reports frame status.
module mrd_sink_buf_wr (
    input  logic        clk,
    input  logic        rst,
    input  logic        sink_valid,
    output logic        sink_ready,
    input  logic        sink_sop,
    input  logic        sink_eop,
    input  logic [17:0] sink_real,
    input  logic [17:0] sink_imag,
    input  logic [11:0] sink_dftpts,
    input  logic        sink_inverse,
    input  logic        buf_release,
    output logic        wr_en,
    output logic [2:0]  wr_bank,
    output logic [9:0]  wr_addr,
    output logic [17:0] wr_real,
    output logic [17:0] wr_imag,
    output logic [11:0] frame_dftpts,
    output logic        frame_inverse,
    output logic        stat_sink_sop,
    output logic        stat_sink_ongoing,
    output logic        frame_done,
    output logic        err_len
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRecv = 2'd1;
    localparam logic [1:0] StDrop = 2'd2;
    localparam logic [1:0] StHold = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  bank_q, bank_d;
    logic [9:0]  addr_q, addr_d;
    logic [10:0] cnt_q, cnt_d;
    logic [11:0] dftpts_q, dftpts_d;
    logic        inverse_q, inverse_d;
    logic        wr_en_q, wr_en_d;
    logic [2:0]  wr_bank_q, wr_bank_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [17:0] wr_real_q, wr_real_d;
    logic [17:0] wr_imag_q, wr_imag_d;
    logic        sop_q, sop_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic accept, legal, last;

    assign sink_ready = (state_q != StHold);
    assign accept     = sink_valid & sink_ready;
    assign legal      = (sink_dftpts >= 12'd12) && (sink_dftpts <= 12'd1200);
    assign last       = ({1'b0, cnt_q} == (dftpts_q - 12'd1));

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        dftpts_d  = dftpts_q;
        inverse_d = inverse_q;
        wr_en_d   = 1'b0;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        wr_real_d = wr_real_q;
        wr_imag_d = wr_imag_q;
        sop_d     = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (accept) begin
            unique case (state_q)
                StIdle, StRecv: begin
                    if (sink_sop) begin
                        // sop inside a frame aborts it and restarts with the new params
                        if (state_q == StRecv) err_d = 1'b1;
                        if (legal) begin
                            dftpts_d  = sink_dftpts;
                            inverse_d = sink_inverse;
                            sop_d     = 1'b1;
                            wr_en_d   = 1'b1;
                            wr_bank_d = 3'd0;
                            wr_addr_d = 10'd0;
                            wr_real_d = sink_real;
                            wr_imag_d = sink_imag;
                            bank_d    = 3'd1;
                            addr_d    = 10'd0;
                            cnt_d     = 11'd1;
                            if (sink_eop) begin
                                err_d   = 1'b1;
                                state_d = StIdle;
                            end else begin
                                state_d = StRecv;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = sink_eop ? StIdle : StDrop;
                        end
                    end else if (state_q == StRecv) begin
                        wr_en_d   = 1'b1;
                        wr_bank_d = bank_q;
                        wr_addr_d = addr_q;
                        wr_real_d = sink_real;
                        wr_imag_d = sink_imag;
                        if (bank_q == 3'd4) begin
                            bank_d = 3'd0;
                            addr_d = addr_q + 10'd1;
                        end else begin
                            bank_d = bank_q + 3'd1;
                        end
                        cnt_d = cnt_q + 11'd1;
                        if (last) begin
                            if (sink_eop) begin
                                done_d  = 1'b1;
                                state_d = StHold;
                            end else begin
                                err_d   = 1'b1;
                                state_d = StDrop;
                            end
                        end else if (sink_eop) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (sink_eop) state_d = StIdle;
                end
                default: ;
            endcase
        end

        if (state_q == StHold && buf_release) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bank_q    <= 3'd0;
            addr_q    <= 10'd0;
            cnt_q     <= 11'd0;
            dftpts_q  <= 12'd0;
            inverse_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= 3'd0;
            wr_addr_q <= 10'd0;
            wr_real_q <= 18'd0;
            wr_imag_q <= 18'd0;
            sop_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            dftpts_q  <= dftpts_d;
            inverse_q <= inverse_d;
            wr_en_q   <= wr_en_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            wr_real_q <= wr_real_d;
            wr_imag_q <= wr_imag_d;
            sop_q     <= sop_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en             = wr_en_q;
    assign wr_bank           = wr_bank_q;
    assign wr_addr           = wr_addr_q;
    assign wr_real           = wr_real_q;
    assign wr_imag           = wr_imag_q;
    assign frame_dftpts      = dftpts_q;
    assign frame_inverse     = inverse_q;
    assign stat_sink_sop     = sop_q;
    assign stat_sink_ongoing = (state_q == StRecv);
    assign frame_done        = done_q;
    assign err_len           = err_q;

endmodule

// File: tb/tb_mrd_sink_buf_wr.sv
// Scoreboard bench for mrd_sink_buf_wr: frame-level model pushes expected output beats,
// an independent monitor pops and compares whenever the DUT emits a write or status pulse.
module tb_mrd_sink_buf_wr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sink_valid = 1'b0;
    logic        sink_ready;
    logic        sink_sop = 1'b0;
    logic        sink_eop = 1'b0;
    logic [17:0] sink_real = '0;
    logic [17:0] sink_imag = '0;
    logic [11:0] sink_dftpts = '0;
    logic        sink_inverse = 1'b0;
    logic        buf_release = 1'b0;
    logic        wr_en;
    logic [2:0]  wr_bank;
    logic [9:0]  wr_addr;
    logic [17:0] wr_real;
    logic [17:0] wr_imag;
    logic [11:0] frame_dftpts;
    logic        frame_inverse;
    logic        stat_sink_sop;
    logic        stat_sink_ongoing;
    logic        frame_done;
    logic        err_len;

    typedef struct packed {
        logic        wr;
        logic [2:0]  bank;
        logic [9:0]  addr;
        logic [17:0] re;
        logic [17:0] im;
        logic        sop;
        logic        done;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e, mon_g;
    int   checks = 0;
    int   errors = 0;
    bit   mid_frame = 1'b0;
    int   last_legal = 0;
    bit   last_inv = 1'b0;

    mrd_sink_buf_wr dut (
        .clk               (clk),
        .rst               (rst),
        .sink_valid        (sink_valid),
        .sink_ready        (sink_ready),
        .sink_sop          (sink_sop),
        .sink_eop          (sink_eop),
        .sink_real         (sink_real),
        .sink_imag         (sink_imag),
        .sink_dftpts       (sink_dftpts),
        .sink_inverse      (sink_inverse),
        .buf_release       (buf_release),
        .wr_en             (wr_en),
        .wr_bank           (wr_bank),
        .wr_addr           (wr_addr),
        .wr_real           (wr_real),
        .wr_imag           (wr_imag),
        .frame_dftpts      (frame_dftpts),
        .frame_inverse     (frame_inverse),
        .stat_sink_sop     (stat_sink_sop),
        .stat_sink_ongoing (stat_sink_ongoing),
        .frame_done        (frame_done),
        .err_len           (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitor: sample 1 time unit after the edge, pop one expectation per active output beat.
    always @(posedge clk) begin
        #1;
        if (wr_en | stat_sink_sop | frame_done | err_len) begin
            checks++;
            mon_g = '{wr: wr_en, bank: wr_bank, addr: wr_addr, re: wr_real, im: wr_imag,
                      sop: stat_sink_sop, done: frame_done, err: err_len};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got wr=%0d bank=%0d addr=%0d sop=%0d done=%0d err=%0d",
                         wr_en, wr_bank, wr_addr, stat_sink_sop, frame_done, err_len);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_g.wr !== mon_e.wr || mon_g.sop !== mon_e.sop || mon_g.done !== mon_e.done ||
                    mon_g.err !== mon_e.err ||
                    (mon_e.wr && (mon_g.bank !== mon_e.bank || mon_g.addr !== mon_e.addr ||
                                  mon_g.re !== mon_e.re || mon_g.im !== mon_e.im))) begin
                    errors++;
                    $display("FAIL out_beat got=%h exp=%h", mon_g, mon_e);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic drive_beat(input bit sop, input bit eop, input int dft, input bit inv,
                              input logic [17:0] re, input logic [17:0] im, input bit gaps);
        int budget;
        int g;
        if (gaps) begin
            g = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            sink_valid = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
        sink_valid   = 1'b1;
        sink_sop     = sop;
        sink_eop     = eop;
        sink_dftpts  = sop ? 12'(dft) : 12'($urandom);
        sink_inverse = sop ? inv : 1'($urandom);
        sink_real    = re;
        sink_imag    = im;
        budget = 0;
        while (!sink_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!sink_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout got ready=0 exp ready=1");
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    // Frame-level model: sample k lands at (k mod 5, k div 5); status pulses from frame length rules.
    task automatic send_frame(input int n, input int beats, input bit inv, input bit gaps,
                              input bit with_eop);
        bit   legal;
        int   nw;
        exp_t e;
        logic [17:0] re_a[1300];
        logic [17:0] im_a[1300];
        legal = (n >= 12) && (n <= 1200);
        for (int k = 0; k < beats; k++) begin
            re_a[k] = 18'($urandom);
            im_a[k] = 18'($urandom);
        end
        if (legal) begin
            nw = (beats < n) ? beats : n;
            for (int k = 0; k < nw; k++) begin
                e.wr   = 1'b1;
                e.bank = 3'(k % 5);
                e.addr = 10'(k / 5);
                e.re   = re_a[k];
                e.im   = im_a[k];
                e.sop  = (k == 0);
                e.done = with_eop && (beats == n) && (k == n - 1);
                e.err  = ((k == 0) && mid_frame) ||
                         ((k == nw - 1) && (with_eop ? (beats != n) : (beats > n)));
                exp_q.push_back(e);
            end
            mid_frame  = !with_eop && (beats < n);
            last_legal = n;
            last_inv   = inv;
        end else begin
            e = '0;
            e.err = 1'b1;
            exp_q.push_back(e);
            mid_frame = 1'b0;
        end
        for (int k = 0; k < beats; k++) begin
            drive_beat(k == 0, with_eop && (k == beats - 1), n, inv, re_a[k], im_a[k], gaps);
            if (k == 0 && legal && beats > 1) chk("ongoing_after_sop", int'(stat_sink_ongoing), 1);
        end
        chk("frame_dftpts", int'(frame_dftpts), last_legal);
        chk("frame_inverse", int'(frame_inverse), int'(last_inv));
        if (legal && with_eop && beats == n) begin
            chk("ready_in_hold", int'(sink_ready), 0);
            sink_valid = 1'b1;
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("ready_held_low", int'(sink_ready), 0);
            end
            sink_valid  = 1'b0;
            buf_release = 1'b1;
            @(posedge clk);
            #1;
            buf_release = 1'b0;
            chk("ready_after_release", int'(sink_ready), 1);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_ready", int'(sink_ready), 1);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_bank", int'(wr_bank), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_real | wr_imag), 0);
        chk("rst_frame_dftpts", int'(frame_dftpts), 0);
        chk("rst_frame_inverse", int'(frame_inverse), 0);
        chk("rst_status", int'({stat_sink_sop, stat_sink_ongoing, frame_done, err_len}), 0);
    endtask

    initial begin
        int n;
        int b;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals();

        // Beats before any sop are discarded.
        repeat (3) drive_beat(1'b0, 1'b0, 0, 1'b0, 18'h1234, 18'h0abc, 1'b0);
        drive_beat(1'b0, 1'b1, 0, 1'b0, 18'h1, 18'h2, 1'b0);

        send_frame(12, 12, 1'b0, 1'b0, 1'b1);
        send_frame(1200, 1200, 1'b1, 1'b1, 1'b1);
        send_frame(60, 30, 1'b0, 1'b0, 1'b1);
        send_frame(12, 12, 1'b1, 1'b0, 1'b1);
        send_frame(24, 30, 1'b0, 1'b0, 1'b1);
        chk("idle_after_long_ongoing", int'(stat_sink_ongoing), 0);
        send_frame(12, 12, 1'b0, 1'b0, 1'b1);
        send_frame(0, 15, 1'b1, 1'b1, 1'b1);
        send_frame(1201, 20, 1'b0, 1'b0, 1'b1);
        send_frame(11, 1, 1'b0, 1'b0, 1'b1);
        send_frame(13, 13, 1'b0, 1'b0, 1'b1);

        // sop inside a running frame restarts it.
        send_frame(20, 7, 1'b1, 1'b0, 1'b0);
        send_frame(12, 12, 1'b0, 1'b1, 1'b1);

        // Reset on beat 10 of a 36-point frame.
        send_frame(36, 9, 1'b1, 1'b0, 1'b0);
        sink_valid = 1'b1;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        sink_valid = 1'b0;
        mid_frame  = 1'b0;
        last_legal = 0;
        last_inv   = 1'b0;
        check_reset_vals();
        send_frame(36, 36, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            n = int'($urandom_range(12, 80));
            b = n + int'($urandom_range(0, 6)) - 3;
            send_frame(n, b, 1'($urandom), 1'($urandom), 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrd_sink_buf_wr.md
# mrd_sink_buf_wr

Input stage of the mixed-radix DFT core. Accepts the Avalon-ST-style sample stream (valid/ready/sop/eop, 18-bit I/Q, per-frame dftpts/inverse) and converts it into writes to the 5-bank sample buffer. Bank/address generation is round-robin: sample k goes to bank k mod 5, address k div 5. The block publishes frame status to the controller and holds off new frames until the controller releases the buffer.

## Interface
- No parameters. Widths fixed: 18-bit data, 12-bit dftpts, 3-bit bank, 10-bit addr.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sink_valid  in  1  input beat valid
- sink_ready  out  1  block can accept beat
- sink_sop  in  1  first beat of frame
- sink_eop  in  1  last beat of frame
- sink_real, sink_imag  in  18 each  sample, two's complement
- sink_dftpts  in  12  frame length, sampled on sop beat only
- sink_inverse  in  1  IDFT flag, sampled on sop beat only
- buf_release  in  1  one-cycle pulse from controller: buffer consumed, next frame may start
- wr_en  out  1  buffer write strobe
- wr_bank  out  3  bank index 0..4
- wr_addr  out  10  address within bank
- wr_real, wr_imag  out  18 each  write data
- frame_dftpts  out  12  latched dftpts of current/last frame
- frame_inverse  out  1  latched inverse flag
- stat_sink_sop  out  1  one-cycle pulse on accepted sop
- stat_sink_ongoing  out  1  high in RECV
- frame_done  out  1  one-cycle pulse, good frame fully written
- err_len  out  1  one-cycle pulse, frame length error (short, long, or illegal dftpts)

## Operation
- A beat is accepted when sink_valid & sink_ready.
- The FSM has four states: IDLE, RECV, DROP, HOLD.
- IDLE: sink_ready=1.
  - Accepted beat without sop: discarded silently.
  - Accepted sop with dftpts in 12..1200: latch dftpts/inverse, write sample 0, pulse stat_sink_sop, go to RECV. A single-beat frame is impossible (min 12).
  - Accepted sop with illegal dftpts (0..11 or >1200): pulse err_len, go to DROP. If eop is on the same beat, pulse err_len and stay IDLE.
- RECV: sink_ready=1. Each accepted beat writes sample k; k is tracked by counters bank (0..4, wraps to 0 and increments addr) and cnt (0..dftpts-1). No division is used.
  - eop with cnt==dftpts-1: write it, pulse frame_done, go to HOLD.
  - eop with cnt<dftpts-1 (short): write it, pulse err_len, go to IDLE, no frame_done.
  - cnt==dftpts-1 without eop (long): write it, pulse err_len, go to DROP.
  - sop in RECV: treated as a new frame start. Pulse err_len, restart counters at sample 0 with newly latched params, pulse stat_sink_sop, and stay in RECV (or go to DROP if the new params are illegal).
- DROP: sink_ready=1. Beats are discarded until an accepted eop, then go to IDLE. sop in DROP is ignored.
- HOLD: sink_ready=0. The buffer is owned downstream. buf_release moves the FSM to IDLE.
- buf_release in any state other than HOLD: ignored.
- frame_dftpts/frame_inverse hold their value until the next legal sop.

## Timing
- Reset values:
  - FSM = IDLE; sink_ready = 1.
  - wr_en, stat_sink_sop, stat_sink_ongoing, frame_done, err_len = 0.
  - wr_bank, wr_addr, wr_real, wr_imag, frame_dftpts = 0; frame_inverse = 0.
  - Counters = 0.
- Reset mid-frame aborts the frame with no frame_done and no err_len.
- sink_ready is a combinational decode of registered state, with no dependency on sink_valid.
- Write path is registered: an accepted beat in cycle t gives wr_en/bank/addr/data in cycle t+1.
- stat_sink_sop, frame_done and err_len are registered and align with the wr_en of the triggering beat (cycle t+1).
- stat_sink_ongoing is high in the cycles where state==RECV, i.e. from t+1 after the sop.
- HOLD begins at t+1 after the last beat, so sink_ready=0 from t+1. buf_release at cycle r gives sink_ready=1 at r+1.
- Throughput: one beat per cycle in RECV, with no bubbles required.
- Counter widths: cnt 11 bits (max 1199); addr max 239.

## Test plan
- Reset, then a 12-point frame sent back-to-back:
  - Writes go to (bank, addr) = (0,0),(1,0),(2,0),(3,0),(4,0),(0,1)…(1,2).
  - frame_done coincides with the 12th wr_en; sink_ready drops the next cycle.
  - buf_release brings sink_ready back to 1 one cycle later.
- 1200-point frame with random valid gaps:
  - 1200 writes; last write at bank 4, addr 239; frame_done once.
  - frame_dftpts = 1200; frame_inverse matches the sop value.
- Short frame (dftpts=60, eop on beat 30):
  - 30 writes, err_len pulse with the 30th write, no frame_done.
  - Next legal frame is accepted immediately.
- Long frame (dftpts=24, 30 beats):
  - 24 writes, err_len with the 24th, beats 25..30 dropped with ready=1.
  - FSM in IDLE after the eop.
- Illegal dftpts (0, then 1201):
  - err_len each time, no wr_en, stream drained through eop.
  - Beats before the first sop discarded.
- rst asserted at beat 10 of a 36-point frame:
  - All outputs at reset values the next cycle; no frame_done.
  - A fresh frame after reset writes from (0,0).
